// File: rtl/wb_write_stage.sv
// wb_write_stage: write side of the 8x8 register file. Buffers execute-stage
// results in a 2-entry circular FIFO and retires one entry per enabled cycle.
// Optional feature macro: WB_FORWARD_EN adds operand forwarding from pending
// entries to the decode-stage read ports. Without it, the read data passes through.
module wb_write_stage #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic          ex_regwrite,
  input  logic [AW-1:0] ex_rd,
  input  logic [DW-1:0] ex_result,
  input  logic          wb_enable,
  output logic          RegWrite,
  output logic [AW-1:0] Write_Reg,
  output logic [DW-1:0] Write_Data,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  output logic [DW-1:0] fwd_rs_data,
  output logic [DW-1:0] fwd_rt_data,
  output logic [7:0]    retire_count
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned RC_W  = 8;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // Buffer storage and control state
  logic              ent_rw_q   [DEPTH];
  logic [AW-1:0]     ent_rd_q   [DEPTH];
  logic [DW-1:0]     ent_data_q [DEPTH];
  logic              ent_rw_d   [DEPTH];
  logic [AW-1:0]     ent_rd_d   [DEPTH];
  logic [DW-1:0]     ent_data_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [RC_W-1:0]   retire_q, retire_d;
  logic              ready_q, ready_d;

  logic              head_vld;
  logic              enq;
  logic              deq;

  // Next-state: enqueue at tail, dequeue at head, track occupancy and retirements
  always_comb begin
    head_vld   = reset && (count_q != '0);
    enq        = ex_valid && ready_q;
    deq        = wb_enable && head_vld;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    retire_d   = retire_q;
    ent_rw_d   = ent_rw_q;
    ent_rd_d   = ent_rd_q;
    ent_data_d = ent_data_q;

    if (enq) begin
      ent_rw_d[tail_q]   = ex_regwrite;
      ent_rd_d[tail_q]   = ex_rd;
      ent_data_d[tail_q] = ex_result;
      tail_d             = ~tail_q;
    end

    if (deq) begin
      head_d   = ~head_q;
      retire_d = retire_q + RC_W'(1);
    end

    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Ready is registered from next occupancy, so it never depends on wb_enable combinationally
    ready_d = (count_d < FULL);
  end

  // State register with synchronous active-low reset discarding all pending entries
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q  <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      retire_q <= '0;
      ready_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_rw_q[i]   <= 1'b0;
        ent_rd_q[i]   <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      retire_q   <= retire_d;
      ready_q    <= ready_d;
      ent_rw_q   <= ent_rw_d;
      ent_rd_q   <= ent_rd_d;
      ent_data_q <= ent_data_d;
    end
  end

  // Register-file write port driven straight from the head entry; silent during reset
  always_comb begin
    RegWrite   = 1'b0;
    Write_Reg  = '0;
    Write_Data = '0;
    if (head_vld) begin
      RegWrite   = ent_rw_q[head_q] && wb_enable;
      Write_Reg  = ent_rd_q[head_q];
      Write_Data = ent_data_q[head_q];
    end
  end

  assign ex_ready     = ready_q;
  assign retire_count = retire_q;

`ifdef WB_FORWARD_EN
  logic newer_vld;
  logic newer_idx;

  // Forward from the newest matching pending entry; the newer entry overrides the head
  always_comb begin
    newer_vld   = reset && (count_q == FULL);
    newer_idx   = ~head_q;
    fwd_rs_data = id_rs_data;
    fwd_rt_data = id_rt_data;
    if (head_vld && ent_rw_q[head_q] && (ent_rd_q[head_q] == id_rs)) begin
      fwd_rs_data = ent_data_q[head_q];
    end
    if (newer_vld && ent_rw_q[newer_idx] && (ent_rd_q[newer_idx] == id_rs)) begin
      fwd_rs_data = ent_data_q[newer_idx];
    end
    if (head_vld && ent_rw_q[head_q] && (ent_rd_q[head_q] == id_rt)) begin
      fwd_rt_data = ent_data_q[head_q];
    end
    if (newer_vld && ent_rw_q[newer_idx] && (ent_rd_q[newer_idx] == id_rt)) begin
      fwd_rt_data = ent_data_q[newer_idx];
    end
  end
`else
  // Read addresses are only needed for forwarding
  logic unused_id_addr;
  assign unused_id_addr = ^{id_rs, id_rt};

  // Plain pass-through of register-file read data
  assign fwd_rs_data = id_rs_data;
  assign fwd_rt_data = id_rt_data;
`endif

endmodule

// File: doc/wb_write_stage.md
# wb_write_stage

- Write-back stage of the 8-bit pipelined processor; it is the write side of the 8×8-bit register file.
- Accepts completed results from the execute stage over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Drives the register file's RegWrite / Write_Reg / Write_Data port one entry per enabled cycle.
- Optionally forwards pending results back to the decode-stage read ports.

## Interface
Parameters:
- DEPTH, 2: buffer entries; only 2 is supported.
- DW, 8: data width.
- AW, 3: register address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- ex_valid  in  1  execute stage presents a result
- ex_ready  out  1  stage can accept a result this cycle
- ex_regwrite  in  1  result targets a register (decode of instruction bit 7 = 0)
- ex_rd  in  AW  destination register
- ex_result  in  DW  ALU result
- wb_enable  in  1  register-file port available this cycle
- RegWrite  out  1  register-file write strobe
- Write_Reg  out  AW  register-file write address
- Write_Data  out  DW  register-file write data
- id_rs, id_rt  in  AW  decode-stage read addresses
- id_rs_data, id_rt_data  in  DW  raw register-file read data
- fwd_rs_data, fwd_rt_data  out  DW  operand data delivered to decode
- retire_count  out  8  entries retired, modulo 256

## Operation
- State: a 2-entry circular buffer. Each entry holds {regwrite, rd, data}. The buffer has a head pointer, a tail pointer, and a 2-bit count (0–2).
- Enqueue: occurs when ex_valid && ex_ready. The entry is written at the tail and the tail advances.
- ex_ready = (count < 2). It is a pure function of registered state, with no combinational path from wb_enable.
- Dequeue: occurs when wb_enable && count > 0. The head advances and retire_count increments, including for entries with regwrite = 0.
- Write port outputs are combinational from the head entry:
  - RegWrite = (count > 0) && head.regwrite && wb_enable.
  - Write_Reg and Write_Data equal the head fields when count > 0; otherwise 0.
- Register 0 is not hard-wired. A write to rd = 0 is issued like any other write.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
  - With count = 2, no enqueue is possible, since ex_ready = 0.
  - A dequeue with count = 0 is a no-op.
- Wrap-around:
  - Head and tail pointers are 1 bit wide and toggle.
  - retire_count wraps from 255 to 0.

## Timing
- While reset is low, at each clock edge: count, head, tail and retire_count are cleared to 0 and all entries are invalidated.
- Reset values of outputs:
  - ex_ready = 0 while reset is low, and 1 in the first cycle after reset deasserts.
  - RegWrite = 0, Write_Reg = 0, Write_Data = 0, retire_count = 0.
  - fwd_rs_data = id_rs_data and fwd_rt_data = id_rt_data.
- A reset asserted mid-operation discards all pending entries. No write strobe is issued in the reset cycle.
- Latency:
  - A result accepted at edge N into an empty buffer drives RegWrite during cycle N+1, provided wb_enable = 1.
  - The register file captures the value in that cycle.
- Throughput is 1 result per cycle while wb_enable stays high.
- With wb_enable held low, at most 2 results are accepted, after which ex_ready drops.

## Configuration
- WB_FORWARD_EN defined: fwd_rs_data is the data of the newest pending entry (tail-most) with regwrite = 1 and rd == id_rs; if none exists, it is id_rs_data. fwd_rt_data follows the same rule using id_rt.
  - The head entry being written this cycle counts as pending.
  - Forwarding is combinational.
- WB_FORWARD_EN undefined: fwd_rs_data = id_rs_data and fwd_rt_data = id_rt_data. No comparators are synthesized.

## Test plan
- Reset with ex_valid = 1 held: check ex_ready = 0, RegWrite = 0, retire_count = 0. Release reset: check ex_ready = 1 on the next cycle.
- Accept {1, rd = 3, 0x5A} with wb_enable = 1: check that the next cycle has RegWrite = 1, Write_Reg = 3, Write_Data = 0x5A, and that retire_count becomes 1.
- Hold wb_enable = 0 and offer 3 results: check that the first 2 are accepted and ex_ready = 0. Raise wb_enable: check the writes occur in order on consecutive cycles, then ex_ready returns to 1.
- Accept a result with ex_regwrite = 0: check RegWrite stays 0 and retire_count still increments.
- With WB_FORWARD_EN: buffer {rd = 2, 0x11} then {rd = 2, 0x22} with wb_enable = 0 and id_rs = 2, id_rs_data = 0x02. Check fwd_rs_data = 0x22. Without the macro, check fwd_rs_data = 0x02.
- Retire 256 results: check retire_count wraps to 0. Assert reset with 2 entries pending: check no RegWrite occurs afterward.
